switches: RTL

- Input-side counterpart to the board LED driver: samples raw slide switches and push-buttons.
- Synchronises and debounces each bit, then presents a clean level, one-cycle edge pulses, and a sticky change-event register with a valid/ack handshake.
- Sits between the board input pins and the lab datapath / memory-mapped I/O.

---
 rtl/switches.sv | 84 ++++++++
 1 files changed

// File: rtl/switches.sv
// Board input conditioner: two-flop synchroniser, per-bit debounce, edge pulses
// and a sticky change-event mask with a valid/ack handshake.
module switches #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_bits,
    input  logic             evt_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0]            sw_q, sw_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic [WIDTH-1:0]            evt_q, evt_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchroniser shift, debounce counters, pulses and event mask
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        sw_d    = sw_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == sw_q[i]) begin
                // Any return to the accepted level discards accumulated credit
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_d[i]  = sync2_q[i];
                cnt_d[i] = {CNT_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        rise_d = sw_d & ~sw_q;
        fall_d = ~sw_d & sw_q;
        // A bit changing at the ack edge stays set
        if (evt_ack) begin
            evt_d = rise_d | fall_d;
        end else begin
            evt_d = evt_q | rise_d | fall_d;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= {WIDTH{1'b0}};
            sync2_q <= {WIDTH{1'b0}};
            sw_q    <= {WIDTH{1'b0}};
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            evt_q   <= {WIDTH{1'b0}};
            cnt_q   <= {(WIDTH*CNT_W){1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw        = sw_q;
    assign sw_rise   = rise_q;
    assign sw_fall   = fall_q;
    assign evt_bits  = evt_q;
    assign evt_valid = |evt_q;

endmodule
